// File: rtl/div_seq_pkg.sv
// Shared encodings and helpers for the sequential 32-bit divider.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of an operand; unsigned operands pass through untouched.
    function automatic logic [31:0] mag32(input logic is_signed, input logic [31:0] v);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/div_seq.sv
// Restoring shift-subtract divider, one quotient bit per cycle; result held
// while start_i stays high, cleared when start_i drops or annul_i is raised.
module div_seq
    import div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    div_state_t  state;
    logic [4:0]  cnt;
    // Bit 64 of the work value is always zero until the final step, whose
    // result is taken from work_nxt directly, so it is never stored.
    logic [63:0] work;
    logic [31:0] divisor;
    logic        neg_quot;
    logic        neg_rem;

    logic [32:0] diff;
    logic [64:0] work_nxt;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic        stop;

    always_comb begin
        diff = {1'b0, work[63:32]} - {1'b0, divisor};
        if (diff[32]) begin
            work_nxt = {work[63:0], 1'b0};
        end else begin
            work_nxt = {diff[31:0], work[31:0], 1'b1};
        end
        quot_fix = neg_quot ? neg32(work_nxt[31:0])  : work_nxt[31:0];
        rem_fix  = neg_rem  ? neg32(work_nxt[64:33]) : work_nxt[64:33];
        stop     = annul_i || (start_i == DivStop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                DivFree: begin
                    result_o <= '0;
                    ready_o  <= DivResultNotReady;
                    busy_o   <= 1'b0;
                    if (start_i == DivStart && !annul_i) begin
                        busy_o <= 1'b1;
                        if (opdata2_i == 32'd0) begin
                            state <= DivByZero;
                        end else begin
                            state    <= DivOn;
                            cnt      <= '0;
                            work     <= {31'b0, mag32(signed_div_i, opdata1_i), 1'b0};
                            divisor  <= mag32(signed_div_i, opdata2_i);
                            neg_quot <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                            neg_rem  <= signed_div_i && opdata1_i[31];
                        end
                    end
                end
                DivByZero: begin
                    state  <= stop ? DivFree : DivEnd;
                    busy_o <= 1'b0;
                    result_o <= '0;
                    ready_o  <= stop ? DivResultNotReady : DivResultReady;
                end
                DivOn: begin
                    if (stop) begin
                        state    <= DivFree;
                        busy_o   <= 1'b0;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end else begin
                        work <= work_nxt[63:0];
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state    <= DivEnd;
                            busy_o   <= 1'b0;
                            result_o <= {rem_fix, quot_fix};
                            ready_o  <= DivResultReady;
                        end
                    end
                end
                DivEnd: begin
                    if (stop) begin
                        state    <= DivFree;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have no parameters; iteration count is fixed at 32.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 signed_div_i  input  1  1 = DIV (two's-complement), 0 = DIVU; sampled at acceptance only.
REQ-005 opdata1_i  input  32  dividend; sampled at acceptance only.
REQ-006 opdata2_i  input  32  divisor; sampled at acceptance only.
REQ-007 start_i  input  1  request from EX stage; held high until result consumed.
REQ-008 annul_i  input  1  cancel in-flight division (e.g. flush); wins over start_i.
REQ-009 result_o  output  64  {remainder[31:0], quotient[31:0]}, for HI and LO respectively; registered.
REQ-010 ready_o  output  1  result_o valid; registered.
REQ-011 busy_o  output  1  high in states DIV_ON and DIV_BYZERO; EX forms stall request as start_i && !ready_o.

Function
REQ-012 The FSM SHALL have states DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END.
REQ-013 DIV_FREE: start_i=1 and annul_i=0 is an acceptance (cycle T); opdata2_i==0 -> DIV_BYZERO, else -> DIV_ON with counter=0.
REQ-014 On acceptance with signed_div_i=1, each negative operand SHALL be replaced by its two's complement (magnitude); with signed_div_i=0, operands are used unchanged.
REQ-015 DIV_ON: one restoring shift-subtract step per cycle on a 65-bit work register initialised {32'b0, |dividend|, 1'b0}; per step, diff = work[63:32] - |divisor| (33-bit); if diff negative, shift work left and insert 0; else work = {diff[31:0], work[31:0], 1'b1}.
REQ-016 After the 32nd step (cycle T+32), the FSM SHALL enter DIV_END; quotient = work[31:0], remainder = work[64:33].
REQ-017 Sign fix (signed only): quotient negated when dividend and divisor signs differ; remainder negated when dividend negative; unsigned results are unchanged.
REQ-018 DIV_END: ready_o=1 and result_o holds the final value from cycle T+33 for as long as start_i=1.
REQ-019 DIV_END with start_i=0 -> DIV_FREE; the next cycle has ready_o=0 and result_o=0.
REQ-020 DIV_BYZERO -> DIV_END after one cycle with result_o=0; ready_o=1 from T+2.
REQ-021 annul_i=1 or start_i=0 in DIV_ON or DIV_BYZERO SHALL abort: next state DIV_FREE, ready_o=0, result_o=0, no result produced.
REQ-022 annul_i=1 in DIV_FREE SHALL block acceptance; annul_i=1 in DIV_END -> DIV_FREE.
REQ-023 Operand changes after acceptance SHALL NOT affect the result.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL wrap: quotient 0x80000000, remainder 0; no exception is raised.
REQ-025 A new acceptance is possible in the cycle after returning to DIV_FREE; back-to-back latency is 34 cycles minimum.

Reset
REQ-026 rst=1 at a clock edge SHALL force DIV_FREE, counter=0, work=0, result_o=0, ready_o=0, busy_o=0, overriding any state including mid-division.
REQ-027 Inputs SHALL be ignored in any cycle where rst=1.

Structure
REQ-028 The shared defines file SHALL hold state encodings DivFree/DivByZero/DivOn/DivEnd, DivResultReady/DivResultNotReady and DivStart/DivStop.
REQ-029 div_seq SHALL be a single module with no sub-module; ex instantiates nothing and connects through the pipeline top, which also carries the stall request.

Verification
REQ-030 DIVU 100/7, start held -> ready_o rises at T+33, result_o = {32'd2, 32'd14}.
REQ-031 DIV -7/2 (0xFFFFFFF9 / 2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
REQ-032 DIV 5/0 -> busy_o at T+1, ready_o at T+2, result_o = 0.
REQ-033 Pulse annul_i at T+10 -> ready_o never asserts; FSM in DIV_FREE at T+11; a following 9/3 returns {0, 3}.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> {0, 0x80000000}; start_i dropped in DIV_END -> ready_o=0 and result_o=0 next cycle.
REQ-035 rst pulsed at T+20 -> all outputs 0 on the next cycle; a fresh 100/7 completes in 33 cycles.
